// File: rtl/alu_issue_ctrl.sv
// Operand/issue stage in front of a registered 8-bit ALU: holds REG_A/REG_B and issues EXEC ops.
// Latency: LOAD 1 edge; READ strobe the cycle after accept; EXEC strobe ALU_LATENCY+2 cycles after accept.
// Backpressure: CMD_READY is high only in IDLE; a held command waits until the EXEC round trip completes.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_TYPE,
  input  logic [3:0] CMD_OP,
  input  logic       CMD_DEST,
  input  logic [7:0] CMD_DATA,
  output logic [7:0] ALU_IN_A,
  output logic [7:0] ALU_IN_B,
  output logic [3:0] ALU_OP,
  input  logic [7:0] ALU_RESULT,
  output logic       RES_VALID,
  output logic [7:0] RES_DATA,
  output logic [7:0] REG_A_OUT,
  output logic [7:0] REG_B_OUT
);

  // Command encodings on CMD_TYPE.
  localparam logic [1:0] CMD_LOAD_A = 2'd0;
  localparam logic [1:0] CMD_LOAD_B = 2'd1;
  localparam logic [1:0] CMD_EXEC   = 2'd2;
  localparam logic [1:0] CMD_READ   = 2'd3;

  // Out-of-range latencies are clamped so the 4-bit counter can never wrap or stall at zero.
  localparam int unsigned LAT_CLAMP = (ALU_LATENCY < 1)  ? 1 :
                                      (ALU_LATENCY > 15) ? 15 : ALU_LATENCY;
  localparam logic [3:0]  LAT_INIT  = 4'(LAT_CLAMP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       dest_q,  dest_d;
  logic [7:0] reg_a_q, reg_a_d;
  logic [7:0] reg_b_q, reg_b_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_vld_q,  res_vld_d;

  logic cmd_accept;
  logic accept_exec;
  logic capture;

  assign cmd_accept  = CMD_VALID && CMD_READY;
  assign accept_exec = cmd_accept && (CMD_TYPE == CMD_EXEC);
  assign capture     = (state_q == ST_CAPTURE);

  // State and latency counter registers; reset abandons any in-flight EXEC.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE issues, WAIT counts the ALU latency down, CAPTURE writes back for one edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    CMD_READY = 1'b0;
    case (state_q)
      ST_IDLE: begin
        CMD_READY = 1'b1;
        if (accept_exec) begin
          cnt_d   = LAT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Datapath next-state: loads and READ act only on accept; write-back happens only in CAPTURE,
  // and the two can never coincide because commands are accepted in IDLE only.
  always_comb begin
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    dest_d     = dest_q;
    res_data_d = res_data_q;
    res_vld_d  = 1'b0;

    if (cmd_accept) begin
      case (CMD_TYPE)
        CMD_LOAD_A: reg_a_d = CMD_DATA;
        CMD_LOAD_B: reg_b_d = CMD_DATA;
        CMD_EXEC: begin
          alu_a_d  = reg_a_q;
          alu_b_d  = reg_b_q;
          alu_op_d = CMD_OP;
          dest_d   = CMD_DEST;
        end
        CMD_READ: begin
          res_data_d = CMD_DEST ? reg_b_q : reg_a_q;
          res_vld_d  = 1'b1;
        end
        default: ;
      endcase
    end

    if (capture) begin
      res_data_d = ALU_RESULT;
      res_vld_d  = 1'b1;
      if (dest_q) begin
        reg_b_d = ALU_RESULT;
      end else begin
        reg_a_d = ALU_RESULT;
      end
    end
  end

  // Datapath registers; reset takes priority over any concurrent load or write-back.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      reg_a_q    <= 8'd0;
      reg_b_q    <= 8'd0;
      alu_a_q    <= 8'd0;
      alu_b_q    <= 8'd0;
      alu_op_q   <= 4'd0;
      dest_q     <= 1'b0;
      res_data_q <= 8'd0;
      res_vld_q  <= 1'b0;
    end else begin
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      dest_q     <= dest_d;
      res_data_q <= res_data_d;
      res_vld_q  <= res_vld_d;
    end
  end

  assign ALU_IN_A  = alu_a_q;
  assign ALU_IN_B  = alu_b_q;
  assign ALU_OP    = alu_op_q;
  assign RES_VALID = res_vld_q;
  assign RES_DATA  = res_data_q;
  assign REG_A_OUT = reg_a_q;
  assign REG_B_OUT = reg_b_q;

endmodule
